req_arbiter_8: RTL

Upstream request-capture stage for the 8-to-3 encoder: synchronizes eight asynchronous request lines, latches each rising edge as a pending event, and issues exactly one pending request at a time as a one-hot byte with a valid/ready handshake. Its one-hot output drives the encoder's 8-bit input directly, so the encoder only ever sees legal one-hot codes.

---
 rtl/req_arbiter_pkg.sv | 7 +
 rtl/req_sync_edge.sv | 24 ++
 rtl/req_arbiter_8.sv | 103 ++++++++++
 3 files changed

// File: rtl/req_arbiter_pkg.sv
// Shared constants and FSM state type for the request arbiter.
package req_arbiter_pkg;
  localparam int WIDTH_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/req_sync_edge.sv
// One request line: synchronizer chain, history flop, rising-edge detect.
module req_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], req};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~hist;
endmodule

// File: rtl/req_arbiter_8.sv
// Captures request edges as pending events and grants one at a time, one-hot.
// RR_ARB_EN selects round-robin arbitration; otherwise lowest index wins.
module req_arbiter_8
  import req_arbiter_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req_in,
  output logic [WIDTH-1:0] onehot_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pending,
  output logic             overrun
);
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] win;
  logic [WIDTH-1:0] clr;
  logic             load;
  state_t           state;

  for (genvar i = 0; i < WIDTH; i++) begin : g_line
    req_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_line (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req_in[i]),
      .rise (rise[i])
    );
  end

`ifdef RR_ARB_EN
  localparam int IW = $clog2(WIDTH);
  logic [IW-1:0] ptr;
  logic [IW-1:0] win_idx;
  logic          found;

  // Search starts just past the last grant and wraps around.
  always_comb begin
    int j;
    win     = '0;
    win_idx = ptr;
    found   = 1'b0;
    for (int k = 1; k <= WIDTH; k++) begin
      j = (int'(ptr) + k) % WIDTH;
      if (!found && pending[j]) begin
        found   = 1'b1;
        win[j]  = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr <= IW'(WIDTH - 1);
    else if (load) ptr <= win_idx;
  end
`else
  // Isolate the lowest set bit.
  assign win = pending & (~pending + WIDTH'(1));
`endif

  // The held grant is already out of pending, so the winner is never it.
  assign load = (|pending) && ((state == IDLE) || out_ready);
  assign clr  = load ? win : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | rise;
      overrun <= |(rise & pending & ~clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      onehot_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load) begin
          onehot_out <= win;
          out_valid  <= 1'b1;
          state      <= HOLD;
        end
        HOLD: if (out_ready) begin
          if (load) begin
            onehot_out <= win;
          end else begin
            onehot_out <= '0;
            out_valid  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
